tiny1_irqctl: RTL and testbench

//  Interrupt controller directly upstream of the tiny1 core's irq/irqack pair.
//  - Collects NSRC asynchronous interrupt sources and synchronises them.
//  - Latches rising edges into a pending register, masks them, and drives the core's single irq line.
//  - On the core's irqack rising edge, captures the highest-priority source into CAUSE for the handler to read.
//  - Register file is memory-mapped in the 16384..65535 area and decoded from the core memory port.

---
 rtl/tiny1_irq_pkg.sv | 32 +++
 rtl/tiny1_irq_sync.sv | 27 ++
 rtl/tiny1_irqctl.sv | 124 ++++++++++++
 tb/tb_tiny1_irqctl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny1_irq_pkg.sv
// Shared definitions for the tiny1 interrupt controller: register offsets,
// CAUSE layout and the lowest-index-wins priority encoder.
package tiny1_irq_pkg;

  localparam logic [3:0] IRQ_OFF_PENDING = 4'h0;
  localparam logic [3:0] IRQ_OFF_MASK    = 4'h2;
  localparam logic [3:0] IRQ_OFF_CAUSE   = 4'h4;
  localparam logic [3:0] IRQ_OFF_CLEAR   = 4'h6;
  localparam logic [3:0] IRQ_OFF_SWTRIG  = 4'h8;

  localparam int CAUSE_VALID_BIT = 15;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } prio_t;

  // Index 0 is the highest priority, so scanning downward lets the lowest set bit win.
  function automatic prio_t prio_lowest(input logic [15:0] v);
    prio_t r;
    r.valid = 1'b0;
    r.idx   = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) begin
        r.valid = 1'b1;
        r.idx   = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tiny1_irq_sync.sv
// Per-source synchroniser chain followed by a rising-edge detector.
// rise is high for exactly one clock per synchronised 0->1 transition.
module tiny1_irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   last_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain  <= '0;
      last_q <= 1'b0;
    end else begin
      chain  <= {chain[SYNC_STAGES-2:0], d};
      last_q <= chain[SYNC_STAGES-1];
    end
  end

  assign rise = chain[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/tiny1_irqctl.sv
// Interrupt controller feeding the tiny1 core irq/irqack pair, with a small MMIO register file.
// Optional build macro TINY1_IRQCTL_SWTRIG_EN adds the software-trigger register at +8.
module tiny1_irqctl
  import tiny1_irq_pkg::*;
#(
  parameter int          NSRC        = 8,
  parameter logic [15:0] BASE_ADDR   = 16'hFF00,
  parameter int          SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src,
  output logic            irq,
  input  logic            irqack,
  input  logic [15:0]     mem_addr,
  input  logic [15:0]     mem_data_o,
  input  logic            mem_wr,
  input  logic            mem_rd,
  output logic [15:0]     mmio_rdata,
  output logic            mmio_rsel
);

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] active;
  logic [NSRC-1:0] set_vec;
  logic [NSRC-1:0] clr_vec;
  logic [NSRC-1:0] pending_nxt;
  logic [3:0]      off;
  logic            hit;
  logic            wr_hit;
  logic            rd_hit;
  logic            irqack_q;
  logic            capture;
  prio_t           top;
  logic            cause_valid;
  logic [3:0]      cause_idx;
  logic [15:0]     rd_mux;
  logic            unused_data;

  assign hit    = (mem_addr[15:4] == BASE_ADDR[15:4]);
  assign off    = mem_addr[3:0];
  assign wr_hit = mem_wr & hit;
  assign rd_hit = mem_rd & hit;

  assign unused_data = ^mem_data_o[15:NSRC];

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_sync
    tiny1_irq_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (src[gi]),
      .rise (rise[gi])
    );
  end

  assign active  = pending & mask;
  assign top     = prio_lowest(16'(active));
  assign capture = irqack & ~irqack_q;

  // Set sources beat clear sources, so a same-cycle edge survives a CLEAR or an ack capture.
  always_comb begin
    set_vec = rise;
`ifdef TINY1_IRQCTL_SWTRIG_EN
    if (wr_hit && (off == IRQ_OFF_SWTRIG)) begin
      set_vec = set_vec | mem_data_o[NSRC-1:0];
    end
`endif
    clr_vec = '0;
    if (wr_hit && (off == IRQ_OFF_CLEAR)) begin
      clr_vec = mem_data_o[NSRC-1:0];
    end
    for (int i = 0; i < NSRC; i++) begin
      if (capture && top.valid && (top.idx == 4'(i))) begin
        clr_vec[i] = 1'b1;
      end
    end
    pending_nxt = (pending & ~clr_vec) | set_vec;
  end

  always_comb begin
    rd_mux = '0;
    case (off)
      IRQ_OFF_PENDING: rd_mux = 16'(pending);
      IRQ_OFF_MASK:    rd_mux = 16'(mask);
      IRQ_OFF_CAUSE: begin
        rd_mux[CAUSE_VALID_BIT] = cause_valid;
        rd_mux[3:0]             = cause_idx;
      end
      default:         rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending     <= '0;
      mask        <= '0;
      irqack_q    <= 1'b0;
      cause_valid <= 1'b0;
      cause_idx   <= 4'd0;
      irq         <= 1'b0;
      mmio_rdata  <= 16'h0000;
      mmio_rsel   <= 1'b0;
    end else begin
      pending  <= pending_nxt;
      irqack_q <= irqack;
      irq      <= (|active) & ~irqack;
      if (wr_hit && (off == IRQ_OFF_MASK)) begin
        mask <= mem_data_o[NSRC-1:0];
      end
      // A capture with nothing eligible records an invalid CAUSE (index 0, valid 0).
      if (capture) begin
        cause_valid <= top.valid;
        cause_idx   <= top.idx;
      end
      mmio_rsel  <= rd_hit;
      mmio_rdata <= rd_hit ? rd_mux : 16'h0000;
    end
  end

endmodule

// File: tb/tb_tiny1_irqctl.sv
// Directed self-checking bench for tiny1_irqctl (default parameters).
// Inputs change on the falling clock edge; outputs are sampled on the falling edge.
module tb_tiny1_irqctl;

  localparam int          SYNC_STAGES = 2;
  localparam logic [15:0] A_PENDING   = 16'hFF00;
  localparam logic [15:0] A_MASK      = 16'hFF02;
  localparam logic [15:0] A_CAUSE     = 16'hFF04;
  localparam logic [15:0] A_CLEAR     = 16'hFF06;
  localparam logic [15:0] A_SWTRIG    = 16'hFF08;

  logic        clk;
  logic        rst;
  logic [7:0]  src;
  logic        irq;
  logic        irqack;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_o;
  logic        mem_wr;
  logic        mem_rd;
  logic [15:0] mmio_rdata;
  logic        mmio_rsel;

  int total = 0;
  int bad   = 0;

  tiny1_irqctl #(
    .NSRC        (8),
    .BASE_ADDR   (16'hFF00),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .src        (src),
    .irq        (irq),
    .irqack     (irqack),
    .mem_addr   (mem_addr),
    .mem_data_o (mem_data_o),
    .mem_wr     (mem_wr),
    .mem_rd     (mem_rd),
    .mmio_rdata (mmio_rdata),
    .mmio_rsel  (mmio_rsel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mmio_write(input logic [15:0] addr, input logic [15:0] data);
    mem_addr   = addr;
    mem_data_o = data;
    mem_wr     = 1'b1;
    @(negedge clk);
    mem_wr     = 1'b0;
  endtask

  task automatic mmio_read(input logic [15:0] addr, output logic [15:0] data, output logic sel);
    mem_addr = addr;
    mem_rd   = 1'b1;
    @(negedge clk);
    mem_rd = 1'b0;
    data   = mmio_rdata;
    sel    = mmio_rsel;
  endtask

  task automatic test_reset;
    logic [15:0] rd;
    logic        sel;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL reset_irq: got %b want 0", irq); end
    total++; if (mmio_rsel !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsel: got %b want 0", mmio_rsel); end
    total++; if (mmio_rdata !== 16'h0000) begin bad++; $display("[TB] FAIL reset_rdata: got %h want 0000", mmio_rdata); end
    tick(2);
    rst = 1'b1;
    tick(1);
    mmio_read(A_PENDING, rd, sel);
    total++; if (rd !== 16'h0000) begin bad++; $display("[TB] FAIL reset_pending: got %h want 0000", rd); end
    total++; if (sel !== 1'b1) begin bad++; $display("[TB] FAIL read_rsel: got %b want 1", sel); end
    mmio_read(A_MASK, rd, sel);
    total++; if (rd !== 16'h0000) begin bad++; $display("[TB] FAIL reset_mask: got %h want 0000", rd); end
    mmio_read(A_CAUSE, rd, sel);
    total++; if (rd !== 16'h0000) begin bad++; $display("[TB] FAIL reset_cause: got %h want 0000", rd); end
  endtask

  task automatic test_regmap;
    logic [15:0] rd;
    logic        sel;
    mmio_write(A_MASK, 16'h00A5);
    mmio_read(A_MASK, rd, sel);
    total++; if (rd !== 16'h00A5) begin bad++; $display("[TB] FAIL mask_rw: got %h want 00a5", rd); end
    mmio_write(A_MASK, 16'hFFFF);
    mmio_read(A_MASK, rd, sel);
    total++; if (rd !== 16'h00FF) begin bad++; $display("[TB] FAIL mask_upper: got %h want 00ff", rd); end
    mmio_read(A_CLEAR, rd, sel);
    total++; if (rd !== 16'h0000) begin bad++; $display("[TB] FAIL clear_reads0: got %h want 0000", rd); end
    mmio_read(16'hFF0A, rd, sel);
    total++; if (rd !== 16'h0000) begin bad++; $display("[TB] FAIL unused_off: got %h want 0000", rd); end
    mmio_write(16'hFE02, 16'h0000);
    mmio_read(A_MASK, rd, sel);
    total++; if (rd !== 16'h00FF) begin bad++; $display("[TB] FAIL miss_write: got %h want 00ff", rd); end
    mmio_read(16'hFF12, rd, sel);
    total++; if (sel !== 1'b0) begin bad++; $display("[TB] FAIL miss_rsel: got %b want 0", sel); end
    mmio_write(A_MASK, 16'h0000);
  endtask

  task automatic test_edge_mask;
    logic [15:0] rd;
    logic        sel;
    bit          found;
    mmio_write(A_MASK, 16'h0008);
    src[3] = 1'b1;
    found  = 1'b0;
    rd     = 16'h0000;
    for (int i = 0; i < SYNC_STAGES + 2 && !found; i++) begin
      mmio_read(A_PENDING, rd, sel);
      if (rd === 16'h0008) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("[TB] FAIL edge_pending: got %h want 0008", rd); end
    total++; if (irq !== 1'b1) begin bad++; $display("[TB] FAIL edge_irq: got %b want 1", irq); end
    src[3] = 1'b0;
    mmio_write(A_CLEAR, 16'h0008);
    tick(1);
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL clear_irq: got %b want 0", irq); end
    mmio_read(A_PENDING, rd, sel);
    total++; if (rd !== 16'h0000) begin bad++; $display("[TB] FAIL clear_pending: got %h want 0000", rd); end
    tick(3);
  endtask

  task automatic test_ack_capture;
    logic [15:0] rd;
    logic        sel;
    mmio_write(A_MASK, 16'h00FF);
    src = 8'h24;
    tick(5);
    mmio_read(A_PENDING, rd, sel);
    total++; if (rd !== 16'h0024) begin bad++; $display("[TB] FAIL ack_pend_pre: got %h want 0024", rd); end
    total++; if (irq !== 1'b1) begin bad++; $display("[TB] FAIL ack_irq_pre: got %b want 1", irq); end
    irqack = 1'b1;
    tick(1);
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL ack_irq_drop: got %b want 0", irq); end
    mmio_read(A_CAUSE, rd, sel);
    total++; if (rd !== 16'h8002) begin bad++; $display("[TB] FAIL ack_cause: got %h want 8002", rd); end
    mmio_read(A_PENDING, rd, sel);
    total++; if (rd !== 16'h0020) begin bad++; $display("[TB] FAIL ack_pend_post: got %h want 0020", rd); end
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL ack_irq_held: got %b want 0", irq); end
    irqack = 1'b0;
    tick(1);
    total++; if (irq !== 1'b1) begin bad++; $display("[TB] FAIL ack_irq_reassert: got %b want 1", irq); end
    mmio_read(A_CAUSE, rd, sel);
    total++; if (rd !== 16'h8002) begin bad++; $display("[TB] FAIL cause_hold: got %h want 8002", rd); end
    irqack = 1'b1;
    tick(1);
    irqack = 1'b0;
    tick(1);
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL ack2_irq: got %b want 0", irq); end
    mmio_read(A_CAUSE, rd, sel);
    total++; if (rd !== 16'h8005) begin bad++; $display("[TB] FAIL ack2_cause: got %h want 8005", rd); end
    mmio_read(A_PENDING, rd, sel);
    total++; if (rd !== 16'h0000) begin bad++; $display("[TB] FAIL ack2_pend: got %h want 0000", rd); end
    src = 8'h00;
    tick(3);
  endtask

  task automatic test_mask_late;
    logic [15:0] rd;
    logic        sel;
    mmio_write(A_MASK, 16'h0000);
    src[1] = 1'b1;
    tick(5);
    mmio_read(A_PENDING, rd, sel);
    total++; if (rd !== 16'h0002) begin bad++; $display("[TB] FAIL masked_pend: got %h want 0002", rd); end
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL masked_irq: got %b want 0", irq); end
    mmio_write(A_MASK, 16'h0002);
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL unmask_irq_1: got %b want 0", irq); end
    tick(1);
    total++; if (irq !== 1'b1) begin bad++; $display("[TB] FAIL unmask_irq_2: got %b want 1", irq); end
  endtask

  task automatic test_mask_before_ack;
    logic [15:0] rd;
    logic        sel;
    mmio_write(A_MASK, 16'h0000);
    irqack = 1'b1;
    tick(1);
    mmio_read(A_CAUSE, rd, sel);
    total++; if (rd !== 16'h0000) begin bad++; $display("[TB] FAIL empty_cause: got %h want 0000", rd); end
    mmio_read(A_PENDING, rd, sel);
    total++; if (rd !== 16'h0002) begin bad++; $display("[TB] FAIL empty_pend: got %h want 0002", rd); end
    irqack = 1'b0;
    tick(1);
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL empty_irq: got %b want 0", irq); end
    mmio_write(A_CLEAR, 16'h0002);
    src[1] = 1'b0;
    tick(3);
  endtask

  task automatic test_clear_priority;
    logic [15:0] rd;
    logic        sel;
    src[4] = 1'b1;
    tick(2);
    // With two sync stages the edge reaches pending on the third clock after src changes.
    mmio_write(A_CLEAR, 16'h0010);
    mmio_read(A_PENDING, rd, sel);
    total++; if (rd !== 16'h0010) begin bad++; $display("[TB] FAIL edge_vs_clear: got %h want 0010", rd); end
    mmio_write(A_CLEAR, 16'h0010);
    mmio_read(A_PENDING, rd, sel);
    total++; if (rd !== 16'h0000) begin bad++; $display("[TB] FAIL clear_after: got %h want 0000", rd); end
    src[4] = 1'b0;
    tick(3);
  endtask

  task automatic test_reset_mid;
    logic [15:0] rd;
    logic        sel;
    mmio_write(A_MASK, 16'h00FF);
    src = 8'h01;
    tick(4);
    irqack = 1'b1;
    tick(1);
    mmio_read(A_CAUSE, rd, sel);
    total++; if (rd !== 16'h8000) begin bad++; $display("[TB] FAIL mid_cause: got %h want 8000", rd); end
    src = 8'h00;
    tick(3);
    src = 8'hFF;
    tick(5);
    mmio_read(A_PENDING, rd, sel);
    total++; if (rd !== 16'h00FF) begin bad++; $display("[TB] FAIL mid_pend: got %h want 00ff", rd); end
    irqack = 1'b0;
    tick(1);
    mem_addr = A_PENDING;
    mem_rd   = 1'b1;
    @(negedge clk);
    mem_rd = 1'b0;
    total++; if (irq !== 1'b1) begin bad++; $display("[TB] FAIL mid_irq_pre: got %b want 1", irq); end
    total++; if (mmio_rsel !== 1'b1) begin bad++; $display("[TB] FAIL mid_rsel_pre: got %b want 1", mmio_rsel); end
    irqack = 1'b1;
    #2 rst = 1'b0;
    #1;
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL async_irq: got %b want 0", irq); end
    total++; if (mmio_rsel !== 1'b0) begin bad++; $display("[TB] FAIL async_rsel: got %b want 0", mmio_rsel); end
    total++; if (mmio_rdata !== 16'h0000) begin bad++; $display("[TB] FAIL async_rdata: got %h want 0000", mmio_rdata); end
    irqack = 1'b0;
    src    = 8'h00;
    tick(3);
    rst = 1'b1;
    tick(2);
    mmio_read(A_PENDING, rd, sel);
    total++; if (rd !== 16'h0000) begin bad++; $display("[TB] FAIL post_pend: got %h want 0000", rd); end
    mmio_read(A_MASK, rd, sel);
    total++; if (rd !== 16'h0000) begin bad++; $display("[TB] FAIL post_mask: got %h want 0000", rd); end
    mmio_read(A_CAUSE, rd, sel);
    total++; if (rd !== 16'h0000) begin bad++; $display("[TB] FAIL post_cause: got %h want 0000", rd); end
  endtask

  task automatic test_swtrig;
    logic [15:0] rd;
    logic        sel;
    mmio_write(A_SWTRIG, 16'h0040);
    mmio_read(A_PENDING, rd, sel);
`ifdef TINY1_IRQCTL_SWTRIG_EN
    total++; if (rd !== 16'h0040) begin bad++; $display("[TB] FAIL swtrig_pend: got %h want 0040", rd); end
`else
    total++; if (rd !== 16'h0000) begin bad++; $display("[TB] FAIL swtrig_off_pend: got %h want 0000", rd); end
`endif
    mmio_read(A_SWTRIG, rd, sel);
    total++; if (rd !== 16'h0000) begin bad++; $display("[TB] FAIL swtrig_read: got %h want 0000", rd); end
    mmio_write(A_CLEAR, 16'h00FF);
  endtask

  initial begin
    rst        = 1'b1;
    src        = 8'h00;
    irqack     = 1'b0;
    mem_addr   = 16'h0000;
    mem_data_o = 16'h0000;
    mem_wr     = 1'b0;
    mem_rd     = 1'b0;
    test_reset();
    test_regmap();
    test_edge_mask();
    test_ack_capture();
    test_mask_late();
    test_mask_before_ack();
    test_clear_priority();
    test_reset_mid();
    test_swtrig();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
